// File: rtl/alu64_pkg.sv
// Shared constants for the 64-bit EX-stage ALU: data width, opcode encodings
// ({inst[30], funct3}) and shifter mode selects.
package alu64_pkg;

   localparam int unsigned DATA_W = 64;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   localparam logic [1:0] SH_SLL = 2'd0;
   localparam logic [1:0] SH_SRL = 2'd1;
   localparam logic [1:0] SH_SRA = 2'd2;

endpackage

// File: rtl/alu64_shifter.sv
// Combinational 64-bit barrel shifter (SLL/SRL/SRA). Only instantiated when
// ALU64_SHIFT_EN is defined.
module alu64_shifter
   import alu64_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [5:0]        shamt,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = '0;
      case (mode)
         SH_SLL:  y = a << shamt;
         SH_SRL:  y = a >> shamt;
         SH_SRA:  y = $signed(a) >>> shamt;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_64bit.sv
// 64-bit EX-stage ALU with one-cycle registered result and carry/overflow/zero flags.
// Shift opcodes are implemented only when ALU64_SHIFT_EN is defined.
module alu_64bit
   import alu64_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        opcode,
   output logic              out_valid,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              overflow,
   output logic              zero
);

   logic              is_sub;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;
   logic              add_ovf;
   logic              slt;
   logic              sltu;

   logic [DATA_W-1:0] result_d, result_q;
   logic              carry_d, carry_q;
   logic              ovf_d, ovf_q;
   logic              valid_q;

   // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
   assign is_sub  = (opcode == OP_SUB);
   assign b_eff   = is_sub ? ~b : b;
   assign sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
   assign add_ovf = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
   assign slt     = $signed(a) < $signed(b);
   assign sltu    = a < b;

`ifdef ALU64_SHIFT_EN
   logic [1:0]        sh_mode;
   logic [DATA_W-1:0] sh_y;

   always_comb begin
      sh_mode = SH_SLL;
      case (opcode)
         OP_SRL:  sh_mode = SH_SRL;
         OP_SRA:  sh_mode = SH_SRA;
         default: sh_mode = SH_SLL;
      endcase
   end

   alu64_shifter u_shifter (
      .a     (a),
      .shamt (b[5:0]),
      .mode  (sh_mode),
      .y     (sh_y)
   );
`endif

   always_comb begin
      result_d = '0;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB: begin
            result_d = sum[DATA_W-1:0];
            carry_d  = sum[DATA_W];
            ovf_d    = add_ovf;
         end
         OP_SLT:  result_d = {{(DATA_W-1){1'b0}}, slt};
         OP_SLTU: result_d = {{(DATA_W-1){1'b0}}, sltu};
         OP_XOR:  result_d = a ^ b;
         OP_OR:   result_d = a | b;
         OP_AND:  result_d = a & b;
`ifdef ALU64_SHIFT_EN
         OP_SLL, OP_SRL, OP_SRA: result_d = sh_y;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_64bit.sv
// Directed self-checking bench for alu_64bit; expectations follow ALU64_SHIFT_EN.
module tb_alu_64bit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [63:0] a;
   logic [63:0] b;
   logic [3:0]  opcode;
   logic        out_valid;
   logic [63:0] result;
   logic        carry;
   logic        overflow;
   logic        zero;

   int compared   = 0;
   int mismatched = 0;

   alu_64bit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [63:0] e_res, input logic e_c,
                          input logic e_ov, input logic e_z, input logic e_v);
      chk({tag, ".result"},    result,    e_res);
      chk({tag, ".carry"},     {63'd0, carry},     {63'd0, e_c});
      chk({tag, ".overflow"},  {63'd0, overflow},  {63'd0, e_ov});
      chk({tag, ".zero"},      {63'd0, zero},      {63'd0, e_z});
      chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, e_v});
   endtask

   // Drive one valid operation at a point away from the edge, then sample 1 time unit after the edge.
   task automatic op(input logic [3:0] opc, input logic [63:0] va, input logic [63:0] vb);
      opcode   = opc;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [63:0] sh_exp;

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      opcode   = '0;

      // Reset held low with random, valid inputs
      for (int i = 0; i < 4; i++) begin
         a        = {$urandom, $urandom};
         b        = {$urandom, $urandom};
         opcode   = 4'($urandom_range(0, 15));
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      chk_out("reset_hold", 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      chk_out("post_release_idle", 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      op(4'b0000, 64'd5, 64'd7);
      chk_out("add_5_7", 64'd12, 1'b0, 1'b0, 1'b0, 1'b1);

      op(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      chk_out("add_sovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

      op(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      chk_out("add_carry", 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      op(4'b1000, 64'd9, 64'd9);
      chk_out("sub_eq", 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      op(4'b1000, 64'd3, 64'd5);
      chk_out("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);

      op(4'b1000, 64'h8000_0000_0000_0000, 64'd1);
      chk_out("sub_sovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);

      op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      chk_out("slt_neg", 64'd1, 1'b0, 1'b0, 1'b0, 1'b1);

      op(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      chk_out("sltu_big", 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      op(4'b0111, 64'hF0F0, 64'h0FF0);
      chk_out("and", 64'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);
      op(4'b0110, 64'hF0F0, 64'h0FF0);
      chk_out("or_b2b", 64'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1);
      op(4'b0100, 64'hF0F0, 64'h0FF0);
      chk_out("xor", 64'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);

      // Shifts: b[63:6] must be ignored
`ifdef ALU64_SHIFT_EN
      sh_exp = 64'hF000_0000_0000_0000;
`else
      sh_exp = 64'd0;
`endif
      op(4'b1101, 64'h8000_0000_0000_0000, 64'h43);
      chk_out("sra_3", sh_exp, 1'b0, 1'b0, sh_exp == 64'd0, 1'b1);

`ifdef ALU64_SHIFT_EN
      sh_exp = 64'h8000_0000_0000_0000;
`else
      sh_exp = 64'd0;
`endif
      op(4'b0001, 64'd1, 64'd63);
      chk_out("sll_63", sh_exp, 1'b0, 1'b0, sh_exp == 64'd0, 1'b1);

`ifdef ALU64_SHIFT_EN
      sh_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
      sh_exp = 64'd0;
`endif
      op(4'b1101, 64'h8000_0000_0000_0001, 64'd63);
      chk_out("sra_63", sh_exp, 1'b0, 1'b0, sh_exp == 64'd0, 1'b1);

`ifdef ALU64_SHIFT_EN
      sh_exp = 64'h0800_0000_0000_0000;
`else
      sh_exp = 64'd0;
`endif
      op(4'b0101, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0104);
      chk_out("srl_4", sh_exp, 1'b0, 1'b0, sh_exp == 64'd0, 1'b1);

`ifdef ALU64_SHIFT_EN
      sh_exp = 64'h1234;
`else
      sh_exp = 64'd0;
`endif
      op(4'b0001, 64'h1234, 64'h40);
      chk_out("sll_0", sh_exp, 1'b0, 1'b0, sh_exp == 64'd0, 1'b1);

      // Unsupported opcode with operands that would otherwise carry
      op(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      chk_out("op_1111", 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      op(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      chk_out("op_1001", 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Hold behaviour when in_valid drops
      op(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      op(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      in_valid = 1'b0;
      opcode   = 4'b0000;
      a        = 64'd1;
      b        = 64'd1;
      @(posedge clk);
      #1;
      chk_out("hold", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

      // Mid-operation asynchronous reset
      op(4'b0000, 64'd5, 64'd7);
      op(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      opcode = 4'b0000;
      a      = 64'd100;
      b      = 64'd23;
      #2;
      reset = 1'b0;
      #1;
      chk_out("async_reset", 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      op(4'b0000, 64'd100, 64'd23);
      chk_out("after_reset_add", 64'd123, 1'b0, 1'b0, 1'b0, 1'b1);

      in_valid = 1'b0;
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
